axil_slave_mem_responder: RTL and testbench

AXI4-Lite slave responder fronting a byte-writable register memory.
- Answers write and read transactions from the decoder's M00_AXI master port, and from any other AXI4-Lite initiator in the block design.
- Replaces the VIP slave memory in synthesizable builds.
- Write and read channels run independently, with one outstanding transaction per direction.

---
 rtl/axil_slv_pkg.sv | 15 +
 rtl/axil_slv_regfile.sv | 35 +++
 rtl/axil_slave_mem_responder.sv | 219 +++++++++++++++++++++
 tb/tb_axil_slave_mem_responder.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_slv_pkg.sv
// Shared types and helpers for the AXI4-Lite slave memory responder.
package axil_slv_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_DATA} rd_state_t;

    // Word offset from the base; addresses below the base wrap to huge offsets.
    function automatic logic [63:0] word_index(input logic [63:0] addr, input logic [63:0] base);
        return (addr - base) >> 2;
    endfunction

endpackage

// File: rtl/axil_slv_regfile.sv
// Word-addressed register memory with a byte-strobed write port, a combinational
// read port and asynchronous clear.
module axil_slv_regfile #(
    parameter int DEPTH = 16,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [31:0]      wr_data,
    input  logic [3:0]       wr_strb,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [31:0]      rd_data
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_strb[b]) begin
                    mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/axil_slave_mem_responder.sv
// AXI4-Lite slave fronting a byte-writable register memory, one outstanding
// transaction per direction. Define AXIL_SLV_ADDR_CHECK_EN to answer SLVERR out of range.
module axil_slave_mem_responder
    import axil_slv_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_MEM_DEPTH_WORDS  = 16,
    parameter logic [31:0] C_BASE_ADDR = 32'h0000_0000
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [3:0]                      S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY
);

    localparam int IDX_W = $clog2(C_MEM_DEPTH_WORDS);
`ifdef AXIL_SLV_ADDR_CHECK_EN
    localparam bit ADDR_CHECK = 1'b1;
`else
    localparam bit ADDR_CHECK = 1'b0;
`endif

    wr_state_t        wr_state, wr_state_d;
    logic             aw_ready_q, aw_ready_d, w_ready_q, w_ready_d;
    logic             aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic             aw_ok_q, aw_ok_d;
    logic [IDX_W-1:0] aw_idx_q, aw_idx_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       wstrb_q, wstrb_d;
    logic             bvalid_q, bvalid_d;
    logic [1:0]       bresp_q, bresp_d;
    logic             mem_we;

    rd_state_t        rd_state, rd_state_d;
    logic             ar_ready_q, ar_ready_d;
    logic             rvalid_q, rvalid_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [1:0]       rresp_q, rresp_d;
    logic [31:0]      mem_rd_data;

    logic [63:0]      aw_word, ar_word;
    logic             aw_in_range, ar_in_range;
    logic             unused_prot;

    assign aw_word     = word_index(64'(S_AXI_AWADDR), 64'(C_BASE_ADDR));
    assign ar_word     = word_index(64'(S_AXI_ARADDR), 64'(C_BASE_ADDR));
    assign aw_in_range = aw_word < 64'(C_MEM_DEPTH_WORDS);
    assign ar_in_range = ar_word < 64'(C_MEM_DEPTH_WORDS);
    assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

    axil_slv_regfile #(.DEPTH(C_MEM_DEPTH_WORDS), .IDX_W(IDX_W)) u_regfile (
        .clk     (ACLK),
        .rst_n   (ARESETN),
        .wr_en   (mem_we),
        .wr_idx  (aw_idx_q),
        .wr_data (wdata_q),
        .wr_strb (wstrb_q),
        .rd_idx  (ar_word[IDX_W-1:0]),
        .rd_data (mem_rd_data)
    );

    // AW and W latch independently; the commit happens one edge after both are held.
    always_comb begin
        wr_state_d = wr_state;
        aw_ready_d = aw_ready_q;
        w_ready_d  = w_ready_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        aw_ok_d    = aw_ok_q;
        aw_idx_d   = aw_idx_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        mem_we     = 1'b0;
        case (wr_state)
            W_IDLE: begin
                if (aw_done_q && w_done_q) begin
                    mem_we     = aw_ok_q;
                    bvalid_d   = 1'b1;
                    bresp_d    = aw_ok_q ? RESP_OKAY : RESP_SLVERR;
                    aw_done_d  = 1'b0;
                    w_done_d   = 1'b0;
                    wr_state_d = W_RESP;
                end else begin
                    if (S_AXI_AWVALID && aw_ready_q) begin
                        aw_ready_d = 1'b0;
                        aw_done_d  = 1'b1;
                        aw_idx_d   = aw_word[IDX_W-1:0];
                        aw_ok_d    = !ADDR_CHECK || aw_in_range;
                    end else begin
                        aw_ready_d = !aw_done_q;
                    end
                    if (S_AXI_WVALID && w_ready_q) begin
                        w_ready_d = 1'b0;
                        w_done_d  = 1'b1;
                        wdata_d   = S_AXI_WDATA;
                        wstrb_d   = S_AXI_WSTRB;
                    end else begin
                        w_ready_d = !w_done_q;
                    end
                end
            end
            W_RESP: begin
                if (S_AXI_BREADY) begin
                    bvalid_d   = 1'b0;
                    bresp_d    = RESP_OKAY;
                    aw_ready_d = 1'b1;
                    w_ready_d  = 1'b1;
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    // Read data is captured on the AR handshake edge, so a same-edge write is not yet visible.
    always_comb begin
        rd_state_d = rd_state;
        ar_ready_d = ar_ready_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        case (rd_state)
            R_IDLE: begin
                if (S_AXI_ARVALID && ar_ready_q) begin
                    ar_ready_d = 1'b0;
                    rvalid_d   = 1'b1;
                    if (!ADDR_CHECK || ar_in_range) begin
                        rdata_d = mem_rd_data;
                        rresp_d = RESP_OKAY;
                    end else begin
                        rdata_d = '0;
                        rresp_d = RESP_SLVERR;
                    end
                    rd_state_d = R_DATA;
                end else begin
                    ar_ready_d = 1'b1;
                end
            end
            R_DATA: begin
                if (S_AXI_RREADY) begin
                    rvalid_d   = 1'b0;
                    rdata_d    = '0;
                    rresp_d    = RESP_OKAY;
                    ar_ready_d = 1'b1;
                    rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_state   <= W_IDLE;
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            aw_ok_q    <= 1'b0;
            aw_idx_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            rd_state   <= R_IDLE;
            ar_ready_q <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
        end else begin
            wr_state   <= wr_state_d;
            aw_ready_q <= aw_ready_d;
            w_ready_q  <= w_ready_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            aw_ok_q    <= aw_ok_d;
            aw_idx_q   <= aw_idx_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            rd_state   <= rd_state_d;
            ar_ready_q <= ar_ready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    assign S_AXI_AWREADY = aw_ready_q;
    assign S_AXI_WREADY  = w_ready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = ar_ready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;

endmodule

// File: tb/tb_axil_slave_mem_responder.sv
// Directed testbench for axil_slave_mem_responder; out-of-range expectations follow
// AXIL_SLV_ADDR_CHECK_EN.
module tb_axil_slave_mem_responder;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic [31:0] S_AXI_AWADDR = '0;
    logic [2:0]  S_AXI_AWPROT = '0;
    logic        S_AXI_AWVALID = 1'b0;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA = '0;
    logic [3:0]  S_AXI_WSTRB = '0;
    logic        S_AXI_WVALID = 1'b0;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY = 1'b0;
    logic [31:0] S_AXI_ARADDR = '0;
    logic [2:0]  S_AXI_ARPROT = '0;
    logic        S_AXI_ARVALID = 1'b0;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 ACLK = ~ACLK;

    axil_slave_mem_responder dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWPROT  (S_AXI_AWPROT),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARPROT  (S_AXI_ARPROT),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY)
    );

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    // Simultaneous AW/W, then a B handshake; a response that never comes counts as an error.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp);
        bit aw_hs, w_hs;
        int n;
        resp = 2'bxx;
        S_AXI_AWADDR = addr; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = data; S_AXI_WSTRB = strb; S_AXI_WVALID = 1'b1;
        S_AXI_BREADY = 1'b1;
        n = 0;
        while ((S_AXI_AWVALID || S_AXI_WVALID) && n < 20) begin
            aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
            w_hs  = S_AXI_WVALID && S_AXI_WREADY;
            tick();
            if (aw_hs) S_AXI_AWVALID = 1'b0;
            if (w_hs) S_AXI_WVALID = 1'b0;
            n++;
        end
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        n = 0;
        while (!S_AXI_BVALID && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (!S_AXI_BVALID) begin
            errors++;
            $display("[TB] FAIL write_timeout addr=%h: BVALID=%b, required 1", addr, S_AXI_BVALID);
        end else begin
            resp = S_AXI_BRESP;
        end
        tick();
        S_AXI_BREADY = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int n;
        data = 'x; resp = 2'bxx;
        S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b1;
        n = 0;
        while (!S_AXI_ARREADY && n < 20) begin
            tick();
            n++;
        end
        tick();
        S_AXI_ARVALID = 1'b0;
        n = 0;
        while (!S_AXI_RVALID && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (!S_AXI_RVALID) begin
            errors++;
            $display("[TB] FAIL read_timeout addr=%h: RVALID=%b, required 1", addr, S_AXI_RVALID);
        end else begin
            data = S_AXI_RDATA;
            resp = S_AXI_RRESP;
        end
        tick();
        S_AXI_RREADY = 1'b0;
    endtask

    task automatic test_reset();
        ARESETN = 1'b0;
        tick(); tick();
        checks++;
        if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_BRESP, S_AXI_ARREADY,
             S_AXI_RVALID, S_AXI_RRESP, S_AXI_RDATA} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got aw=%b w=%b b=%b ar=%b r=%b rdata=%h, required all 0",
                     S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RDATA);
        end
        ARESETN = 1'b1;
        #1;
        checks++;
        if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL readys_before_edge: got %b, required 000",
                     {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY});
        end
        tick();
        checks++;
        if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b111) begin
            errors++;
            $display("[TB] FAIL readys_after_release: got %b, required 111",
                     {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY});
        end
    endtask

    task automatic test_simultaneous();
        S_AXI_AWADDR = 32'h8; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = 32'hDEADBEEF; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        S_AXI_BREADY = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        checks++;
        if (S_AXI_BVALID !== 1'b0 || S_AXI_AWREADY !== 1'b0) begin
            errors++;
            $display("[TB] FAIL simul_cycle1: BVALID=%b AWREADY=%b, required 0 0", S_AXI_BVALID, S_AXI_AWREADY);
        end
        tick();
        checks++;
        if (S_AXI_BVALID !== 1'b1 || S_AXI_BRESP !== 2'b00) begin
            errors++;
            $display("[TB] FAIL simul_bvalid: BVALID=%b BRESP=%b, required 1 00", S_AXI_BVALID, S_AXI_BRESP);
        end
        tick();
        S_AXI_BREADY = 1'b0;
        checks++;
        if (S_AXI_BVALID !== 1'b0 || S_AXI_AWREADY !== 1'b1 || S_AXI_WREADY !== 1'b1) begin
            errors++;
            $display("[TB] FAIL simul_after_b: BVALID=%b AWREADY=%b WREADY=%b, required 0 1 1",
                     S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY);
        end
        S_AXI_ARADDR = 32'h8; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
        tick();
        S_AXI_ARVALID = 1'b0;
        checks++;
        if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== 32'hDEADBEEF || S_AXI_RRESP !== 2'b00 || S_AXI_ARREADY !== 1'b0) begin
            errors++;
            $display("[TB] FAIL simul_read: RVALID=%b RDATA=%h RRESP=%b ARREADY=%b, required 1 deadbeef 00 0",
                     S_AXI_RVALID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_ARREADY);
        end
        S_AXI_RREADY = 1'b1;
        tick();
        S_AXI_RREADY = 1'b0;
        checks++;
        if (S_AXI_RVALID !== 1'b0 || S_AXI_ARREADY !== 1'b1) begin
            errors++;
            $display("[TB] FAIL simul_read_done: RVALID=%b ARREADY=%b, required 0 1", S_AXI_RVALID, S_AXI_ARREADY);
        end
    endtask

    task automatic test_order_and_stall();
        logic [31:0] d;
        logic [1:0]  r;
        S_AXI_WDATA = 32'h11223344; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        S_AXI_BREADY = 1'b0;
        tick();
        S_AXI_WVALID = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (S_AXI_BVALID !== 1'b0 || S_AXI_WREADY !== 1'b0 || S_AXI_AWREADY !== 1'b1) begin
                errors++;
                $display("[TB] FAIL w_first_wait%0d: BVALID=%b WREADY=%b AWREADY=%b, required 0 0 1",
                         i, S_AXI_BVALID, S_AXI_WREADY, S_AXI_AWREADY);
            end
            if (i < 2) tick();
        end
        S_AXI_AWADDR = 32'h4; S_AXI_AWVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0;
        checks++;
        if (S_AXI_BVALID !== 1'b0) begin
            errors++;
            $display("[TB] FAIL aw_late_cycle1: BVALID=%b, required 0", S_AXI_BVALID);
        end
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (S_AXI_BVALID !== 1'b1 || S_AXI_BRESP !== 2'b00 || S_AXI_AWREADY !== 1'b0 || S_AXI_WREADY !== 1'b0) begin
                errors++;
                $display("[TB] FAIL b_stall%0d: BVALID=%b BRESP=%b AWREADY=%b WREADY=%b, required 1 00 0 0",
                         i, S_AXI_BVALID, S_AXI_BRESP, S_AXI_AWREADY, S_AXI_WREADY);
            end
            tick();
        end
        S_AXI_BREADY = 1'b1;
        tick();
        S_AXI_BREADY = 1'b0;
        checks++;
        if (S_AXI_BVALID !== 1'b0 || S_AXI_AWREADY !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b_release: BVALID=%b AWREADY=%b, required 0 1", S_AXI_BVALID, S_AXI_AWREADY);
        end
        do_read(32'h4, d, r);
        checks++;
        if (d !== 32'h11223344 || r !== 2'b00) begin
            errors++;
            $display("[TB] FAIL order_readback: got %h/%b, required 11223344/00", d, r);
        end
    endtask

    task automatic test_partial_strobe();
        logic [31:0] d;
        logic [1:0]  r;
        do_write(32'h0, 32'hAABBCCDD, 4'hF, r);
        do_write(32'h0, 32'h00000099, 4'h1, r);
        checks++;
        if (r !== 2'b00) begin
            errors++;
            $display("[TB] FAIL strb1_resp: got %b, required 00", r);
        end
        do_read(32'h0, d, r);
        checks++;
        if (d !== 32'hAABBCC99) begin
            errors++;
            $display("[TB] FAIL strb1_data: got %h, required aabbcc99", d);
        end
        do_write(32'h0, 32'hFFFFFFFF, 4'h0, r);
        checks++;
        if (r !== 2'b00) begin
            errors++;
            $display("[TB] FAIL strb0_resp: got %b, required 00", r);
        end
        do_read(32'h0, d, r);
        checks++;
        if (d !== 32'hAABBCC99) begin
            errors++;
            $display("[TB] FAIL strb0_data: got %h, required aabbcc99", d);
        end
    endtask

    task automatic test_collision();
        logic [31:0] d;
        logic [1:0]  r;
        do_write(32'h8, 32'h1, 4'hF, r);
        S_AXI_AWADDR = 32'h8; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = 32'h2; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        S_AXI_BREADY = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        S_AXI_ARADDR = 32'h8; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
        tick();
        S_AXI_ARVALID = 1'b0;
        checks++;
        if (S_AXI_BVALID !== 1'b1 || S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== 32'h1) begin
            errors++;
            $display("[TB] FAIL collision_old_data: BVALID=%b RVALID=%b RDATA=%h, required 1 1 00000001",
                     S_AXI_BVALID, S_AXI_RVALID, S_AXI_RDATA);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== 32'h1 || S_AXI_ARREADY !== 1'b0) begin
                errors++;
                $display("[TB] FAIL r_stall%0d: RVALID=%b RDATA=%h ARREADY=%b, required 1 00000001 0",
                         i, S_AXI_RVALID, S_AXI_RDATA, S_AXI_ARREADY);
            end
        end
        S_AXI_BREADY = 1'b0;
        S_AXI_RREADY = 1'b1;
        tick();
        S_AXI_RREADY = 1'b0;
        do_read(32'h8, d, r);
        checks++;
        if (d !== 32'h2) begin
            errors++;
            $display("[TB] FAIL collision_new_data: got %h, required 00000002", d);
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] d;
        logic [1:0]  r;
        do_write(32'h40, 32'h12345678, 4'hF, r);
`ifdef AXIL_SLV_ADDR_CHECK_EN
        checks++;
        if (r !== 2'b10) begin
            errors++;
            $display("[TB] FAIL oor_bresp: got %b, required 10", r);
        end
        do_read(32'h40, d, r);
        checks++;
        if (r !== 2'b10 || d !== 32'h0) begin
            errors++;
            $display("[TB] FAIL oor_read: got %h/%b, required 00000000/10", d, r);
        end
        do_read(32'h0, d, r);
        checks++;
        if (d !== 32'hAABBCC99 || r !== 2'b00) begin
            errors++;
            $display("[TB] FAIL oor_word0: got %h/%b, required aabbcc99/00", d, r);
        end
`else
        checks++;
        if (r !== 2'b00) begin
            errors++;
            $display("[TB] FAIL alias_bresp: got %b, required 00", r);
        end
        do_read(32'h40, d, r);
        checks++;
        if (r !== 2'b00 || d !== 32'h12345678) begin
            errors++;
            $display("[TB] FAIL alias_read: got %h/%b, required 12345678/00", d, r);
        end
        do_read(32'h0, d, r);
        checks++;
        if (d !== 32'h12345678 || r !== 2'b00) begin
            errors++;
            $display("[TB] FAIL alias_word0: got %h/%b, required 12345678/00", d, r);
        end
`endif
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic [1:0]  r;
        logic [31:0] addrs [3] = '{32'h0, 32'h4, 32'h8};
        S_AXI_AWADDR = 32'hC; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = 32'h55AA55AA; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        S_AXI_BREADY = 1'b0;
        tick();
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        tick();
        checks++;
        if (S_AXI_BVALID !== 1'b1) begin
            errors++;
            $display("[TB] FAIL pre_reset_bvalid: got %b, required 1", S_AXI_BVALID);
        end
        #2;
        ARESETN = 1'b0;
        #1;
        checks++;
        if (S_AXI_BVALID !== 1'b0 || S_AXI_AWREADY !== 1'b0 || S_AXI_ARREADY !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset: BVALID=%b AWREADY=%b ARREADY=%b, required 0 0 0",
                     S_AXI_BVALID, S_AXI_AWREADY, S_AXI_ARREADY);
        end
        tick(); tick();
        ARESETN = 1'b1;
        tick();
        checks++;
        if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b111 || S_AXI_BVALID !== 1'b0) begin
            errors++;
            $display("[TB] FAIL post_reset_readys: got %b BVALID=%b, required 111 0",
                     {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, S_AXI_BVALID);
        end
        foreach (addrs[i]) begin
            do_read(addrs[i], d, r);
            checks++;
            if (d !== 32'h0 || r !== 2'b00) begin
                errors++;
                $display("[TB] FAIL cleared_word addr=%h: got %h/%b, required 00000000/00", addrs[i], d, r);
            end
        end
    endtask

    initial begin
        $display("[TB] start");
        test_reset();
        test_simultaneous();
        test_order_and_stall();
        test_partial_strobe();
        test_collision();
        test_out_of_range();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
